// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential cascade comparator.
//   NIBBLE_W            : width of one compare slice
//   cmp_res_t           : encoded less / equal / greater result
//   state_t             : control FSM states
//   normalise_cascade() : one-hot (possibly malformed) lt/eq/gt to cmp_res_t,
//                         priority eq > gt > lt, nothing asserted reads as EQ
package cmp_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic cmp_res_t normalise_cascade(input logic lt_in,
                                                   input logic eq_in,
                                                   input logic gt_in);
        if (eq_in) begin
            return CMP_EQ;
        end else if (gt_in) begin
            return CMP_GT;
        end else if (lt_in) begin
            return CMP_LT;
        end
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/cmp_nibble.sv
// Combinational 4-bit cascadable magnitude compare slice.
//   a, b                      : nibble operands, unsigned
//   lt_in, eq_in, gt_in       : result of the less-significant part
//   lt_out, eq_out, gt_out    : one-hot result; the local nibbles decide when
//                               they differ, otherwise the normalised cascade
//                               input passes through
module cmp_nibble
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                lt_in,
    input  logic                eq_in,
    input  logic                gt_in,
    output logic                lt_out,
    output logic                eq_out,
    output logic                gt_out
);

    cmp_res_t pass_res;

    always_comb begin
        lt_out   = 1'b0;
        eq_out   = 1'b0;
        gt_out   = 1'b0;
        pass_res = normalise_cascade(lt_in, eq_in, gt_in);
        if (a > b) begin
            gt_out = 1'b1;
        end else if (a < b) begin
            lt_out = 1'b1;
        end else begin
            lt_out = (pass_res == CMP_LT);
            eq_out = (pass_res == CMP_EQ);
            gt_out = (pass_res == CMP_GT);
        end
    end

endmodule

// File: rtl/cmp_cascade_seq.sv
// Sequential multi-word magnitude comparator. Operands are walked MSB nibble
// first through one cmp_nibble slice; the running result lives in a register
// that also drives the slice's cascade inputs.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b and cascade inputs)
//   a, b                : W-bit unsigned operands, W = 4*NIBBLES
//   lt_in, eq_in, gt_in : result from a less-significant chained block
//   out_valid, out_ready: result handshake
//   lt, eq, gt          : registered one-hot result, zero while out_valid=0
// Parameters:
//   NIBBLES    : operand width in nibbles (1..16)
//   EARLY_EXIT : 1 = finish on the first differing nibble
module cmp_cascade_seq
    import cmp_pkg::*;
#(
    parameter int NIBBLES    = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    lt_in,
    input  logic                    eq_in,
    input  logic                    gt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    lt,
    output logic                    eq,
    output logic                    gt
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NIBBLES - 1);

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, a_next;
    logic [W-1:0]       b_reg, b_next;
    cmp_res_t           casc_reg, casc_next;
    cmp_res_t           run_reg, run_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               out_valid_reg, out_valid_next;
    logic               lt_reg, lt_next;
    logic               eq_reg, eq_next;
    logic               gt_reg, gt_next;

    logic               accept;
    logic               finish;
    cmp_res_t           final_res;

    // Nibble views of the operand registers, selected by the index counter.
    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    // The running state feeds the cascade inputs: while it is EQ the slice
    // result is the plain nibble compare; once it has decided, equal nibbles
    // simply pass the decision through.
    logic     slice_lt, slice_eq, slice_gt;
    cmp_res_t slice_res;

    cmp_nibble u_slice (
        .a      (a_nib[idx_reg]),
        .b      (b_nib[idx_reg]),
        .lt_in  (run_reg == CMP_LT),
        .eq_in  (run_reg == CMP_EQ),
        .gt_in  (run_reg == CMP_GT),
        .lt_out (slice_lt),
        .eq_out (slice_eq),
        .gt_out (slice_gt)
    );

    assign slice_res = normalise_cascade(slice_lt, slice_eq, slice_gt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            casc_reg      <= CMP_EQ;
            run_reg       <= CMP_EQ;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            lt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            gt_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            casc_reg      <= casc_next;
            run_reg       <= run_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            lt_reg        <= lt_next;
            eq_reg        <= eq_next;
            gt_reg        <= gt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        casc_next      = casc_reg;
        run_next       = run_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        lt_next        = lt_reg;
        eq_next        = eq_reg;
        gt_next        = gt_reg;
        in_ready       = 1'b0;
        accept         = 1'b0;
        finish         = 1'b0;
        final_res      = CMP_EQ;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            RUN: begin
                // Only the first difference may change the running state.
                run_next  = (run_reg == CMP_EQ) ? slice_res : run_reg;
                finish    = (idx_reg == '0) ||
                            (EARLY_EXIT && (run_next != CMP_EQ));
                final_res = (run_next == CMP_EQ) ? casc_reg : run_next;
                if (finish) begin
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                    lt_next        = (final_res == CMP_LT);
                    eq_next        = (final_res == CMP_EQ);
                    gt_next        = (final_res == CMP_GT);
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                    lt_next        = 1'b0;
                    eq_next        = 1'b0;
                    gt_next        = 1'b0;
                    accept         = in_valid;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new pair can arrive from IDLE or on the DONE handshake edge.
        if (accept) begin
            a_next     = a;
            b_next     = b;
            casc_next  = normalise_cascade(lt_in, eq_in, gt_in);
            run_next   = CMP_EQ;
            idx_next   = IDX_INIT;
            state_next = RUN;
        end
    end

    assign out_valid = out_valid_reg;
    assign lt        = lt_reg;
    assign eq        = eq_reg;
    assign gt        = gt_reg;

endmodule

// File: tb/tb_cmp_cascade_seq.sv
module tb_cmp_cascade_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        lt_in = 1'b0, eq_in = 1'b0, gt_in = 1'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic        lt0, eq0, gt0, lt1, eq1, gt1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cmp_cascade_seq #(.NIBBLES(4), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .lt_in(lt_in), .eq_in(eq_in), .gt_in(gt_in),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .lt(lt0), .eq(eq0), .gt(gt0)
    );

    cmp_cascade_seq #(.NIBBLES(4), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .lt_in(lt_in), .eq_in(eq_in), .gt_in(gt_in),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .lt(lt1), .eq(eq1), .gt(gt1)
    );

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vlt;
        logic        veq;
        logic        vgt;
        logic [2:0]  exp;   // {lt, eq, gt}
        int          k1;    // early-exit latency
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair to both instances, wait for both results, check the
    // result and latency of each, then drain both with out_ready.
    task automatic run_vec(input int n, input vec_t v);
        int k0, k1;
        logic [2:0] r0, r1;
        k0 = 0; k1 = 0; r0 = '0; r1 = '0;
        a = v.va; b = v.vb; lt_in = v.vlt; eq_in = v.veq; gt_in = v.vgt;
        in_valid0 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        for (int c = 1; c <= 40 && (k0 == 0 || k1 == 0); c++) begin
            tick();
            if (k0 == 0 && out_valid0) begin k0 = c; r0 = {lt0, eq0, gt0}; end
            if (k1 == 0 && out_valid1) begin k1 = c; r1 = {lt1, eq1, gt1}; end
        end
        check($sformatf("v%0d ee0 result", n), int'(r0), int'(v.exp));
        check($sformatf("v%0d ee0 latency", n), k0, 4);
        check($sformatf("v%0d ee1 result", n), int'(r1), int'(v.exp));
        check($sformatf("v%0d ee1 latency", n), k1, v.k1);
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        tick();
        out_ready0 = 1'b0; out_ready1 = 1'b0;
        check($sformatf("v%0d drain", n),
              int'({out_valid0, lt0, eq0, gt0, out_valid1, lt1, eq1, gt1}), 0);
        $display("vec %0d a=%h b=%h casc=%b%b%b res0=%b k0=%0d res1=%b k1=%0d",
                 n, v.va, v.vb, v.vlt, v.veq, v.vgt, r0, k0, r1, k1);
    endtask

    task automatic wait_dut0(input string name, input logic [2:0] exp,
                             input int exp_k);
        int k;
        logic [2:0] r;
        k = 0; r = '0;
        for (int c = 1; c <= 40 && k == 0; c++) begin
            tick();
            if (out_valid0) begin k = c; r = {lt0, eq0, gt0}; end
        end
        check({name, " result"}, int'(r), int'(exp));
        check({name, " latency"}, k, exp_k);
        $display("%s res=%b k=%0d", name, r, k);
    endtask

    initial begin
        logic spurious;

        vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 3'b010, 4};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 3'b001, 1};
        vecs[2] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 3'b100, 4};
        vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 3'b001, 4};
        vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 3'b010, 4};
        vecs[5] = '{16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1, 3'b001, 4};
        vecs[6] = '{16'h1234, 16'h1243, 1'b1, 1'b0, 1'b0, 3'b100, 3};
        vecs[7] = '{16'h0F00, 16'h00FF, 1'b0, 1'b1, 1'b0, 3'b001, 2};
        vecs[8] = '{16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 3'b010, 4};

        repeat (3) tick();
        rst = 1'b0;
        check("reset ee0 outputs",
              int'({out_valid0, lt0, eq0, gt0, in_ready0}), 1);
        check("reset ee1 outputs",
              int'({out_valid1, lt1, eq1, gt1, in_ready1}), 1);
        $display("reset state checked");

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Stall in DONE for three cycles, then handshake with a new pair.
        a = 16'h1234; b = 16'h1243; lt_in = 1'b0; eq_in = 1'b1; gt_in = 1'b0;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        wait_dut0("stall first", 3'b100, 4);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("stall cyc%0d hold", s),
                  int'({out_valid0, lt0, eq0, gt0, in_ready0}), 5'b11000);
            $display("stall cycle %0d out_valid=%b res=%b%b%b in_ready=%b",
                     s, out_valid0, lt0, eq0, gt0, in_ready0);
            tick();
        end
        a = 16'h0001; b = 16'h0002; lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b0;
        in_valid0 = 1'b1; out_ready0 = 1'b1;
        #1;
        check("done in_ready follows out_ready", int'(in_ready0), 1);
        tick();
        in_valid0 = 1'b0; out_ready0 = 1'b0;
        check("overlap accept out_valid low", int'(out_valid0), 0);
        check("overlap accept in_ready low", int'(in_ready0), 0);
        wait_dut0("overlap second", 3'b100, 4);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;

        // Reset during the second RUN cycle discards the operation.
        a = 16'h5555; b = 16'h5555; lt_in = 1'b0; eq_in = 1'b1; gt_in = 1'b0;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-run reset out_valid", int'({out_valid0, lt0, eq0, gt0}), 0);
        check("mid-run reset in_ready", int'(in_ready0), 1);
        spurious = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid0) spurious = 1'b1;
        end
        check("no result after reset", int'(spurious), 0);
        $display("mid-run reset spurious=%b", spurious);
        run_vec(9, '{16'h00FF, 16'h0F00, 1'b0, 1'b0, 1'b0, 3'b100, 2});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
